// File: rtl/eig_sched.sv
// eig_sched: round-robin front end that shares a single eigenvalue core
// between N_REQ requesters. One coefficient pair is in flight at a time. A
// WAIT-state counter bounds the core latency. Results are returned tagged
// with the owning requester ID.
module eig_sched #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*32-1:0]      req_a0,
    input  logic [N_REQ*32-1:0]      req_a1,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     core_start,
    output logic signed [31:0]       core_a0,
    output logic signed [31:0]       core_a1,
    input  logic                     core_done,
    input  logic signed [31:0]       core_kappa,
    input  logic signed [31:0]       core_inv_kappa,
    input  logic [2:0]               core_regime,
    output logic                     res_valid,
    output logic [ID_W-1:0]          res_id,
    output logic signed [31:0]       res_kappa,
    output logic signed [31:0]       res_inv_kappa,
    output logic [2:0]               res_regime,
    output logic                     res_timeout,
    output logic                     busy
);

    // TIMEOUT_CYC >= 4, so TIMEOUT_CYC-1 always fits in clog2(TIMEOUT_CYC) bits
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  hi_idx;
    logic [ID_W-1:0]  lo_idx;
    logic             hi_found;
    logic             gnt_found;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_last;

    assign wait_last = (wait_cnt == CNT_LAST);

    // Round-robin pick: the lowest valid index at or above rr_ptr wins.
    // Otherwise the lowest valid index overall wins, which is the wrap-around.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_idx   = ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        gnt_found = |req_valid;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe outputs; acceptance is masked while reset is held
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        res_valid  = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (gnt_found) begin
                    state_nxt = S_ISSUE;
                    if (rst_n) begin
                        req_ready[gnt_idx] = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (core_done || wait_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                res_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accept: latch operands and owner ID, advance the pointer past the winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            cur_id  <= '0;
            core_a0 <= '0;
            core_a1 <= '0;
        end else if (state == S_IDLE && gnt_found) begin
            rr_ptr  <= (gnt_idx == ID_LAST) ? '0 : gnt_idx + 1'b1;
            cur_id  <= gnt_idx;
            core_a0 <= req_a0[{gnt_idx, 5'b0} +: 32];
            core_a1 <= req_a1[{gnt_idx, 5'b0} +: 32];
        end
    end

    // Timeout counter: cleared on the start pulse, counts every WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Result capture on leaving WAIT; done takes priority over the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_id        <= '0;
            res_kappa     <= '0;
            res_inv_kappa <= '0;
            res_regime    <= '0;
            res_timeout   <= 1'b0;
        end else if (state == S_WAIT) begin
            if (core_done) begin
                res_id        <= cur_id;
                res_kappa     <= core_kappa;
                res_inv_kappa <= core_inv_kappa;
                res_regime    <= core_regime;
                res_timeout   <= 1'b0;
            end else if (wait_last) begin
                res_id        <= cur_id;
                res_kappa     <= '0;
                res_inv_kappa <= '0;
                res_regime    <= '0;
                res_timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eig_sched.sv
// Testbench for eig_sched: randomized requests, a behavioural core model, and a
// scoreboard queue checked by an independent result monitor.
module tb_eig_sched;

    localparam int N = 4;
    localparam int T = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N*32-1:0]      req_a0;
    logic [N*32-1:0]      req_a1;
    logic [N-1:0]         req_ready;
    logic                 core_start;
    logic signed [31:0]   core_a0;
    logic signed [31:0]   core_a1;
    logic                 core_done;
    logic                 core_done_m;
    logic                 core_done_s;
    logic signed [31:0]   core_kappa;
    logic signed [31:0]   core_inv_kappa;
    logic [2:0]           core_regime;
    logic                 res_valid;
    logic [1:0]           res_id;
    logic signed [31:0]   res_kappa;
    logic signed [31:0]   res_inv_kappa;
    logic [2:0]           res_regime;
    logic                 res_timeout;
    logic                 busy;

    assign core_done = core_done_m | core_done_s;

    always #5 clk = ~clk;

    eig_sched #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a0(req_a0), .req_a1(req_a1), .req_ready(req_ready),
        .core_start(core_start), .core_a0(core_a0), .core_a1(core_a1),
        .core_done(core_done), .core_kappa(core_kappa), .core_inv_kappa(core_inv_kappa),
        .core_regime(core_regime),
        .res_valid(res_valid), .res_id(res_id), .res_kappa(res_kappa),
        .res_inv_kappa(res_inv_kappa), .res_regime(res_regime),
        .res_timeout(res_timeout), .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] k;
        logic [31:0] ik;
        logic [2:0]  rg;
        logic        tmo;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          model_ptr = 0;
    int          grant_cyc = 0;
    int          plan_d = -1;
    logic [31:0] plan_k, plan_ik;
    logic [2:0]  plan_rg;
    logic [31:0] exp_a0, exp_a1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 0);
        chk({tag, "_core_start"}, 64'(core_start), 0);
        chk({tag, "_core_a0"}, 64'($unsigned(core_a0)), 0);
        chk({tag, "_core_a1"}, 64'($unsigned(core_a1)), 0);
        chk({tag, "_res_valid"}, 64'(res_valid), 0);
        chk({tag, "_res_id"}, 64'(res_id), 0);
        chk({tag, "_res_kappa"}, 64'($unsigned(res_kappa)), 0);
        chk({tag, "_res_inv_kappa"}, 64'($unsigned(res_inv_kappa)), 0);
        chk({tag, "_res_regime"}, 64'(res_regime), 0);
        chk({tag, "_res_timeout"}, 64'(res_timeout), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
    endtask

    // Reference arbitration: first asserted requester scanning upward from ptr, wrapping
    function automatic int model_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i);
        req_a0[i*32 +: 32] = $urandom;
        req_a1[i*32 +: 32] = $urandom;
    endtask

    // One transaction: request, check the grant, plan the core reply, push the expected result, wait for it
    task automatic run_txn(input logic [N-1:0] mask, input bit hold, input int d,
                           input logic [31:0] k, input logic [31:0] ik, input logic [2:0] rg,
                           output int g);
        int          pg;
        logic [N-1:0] ev;
        exp_t        e;
        g = -1;
        req_valid = mask;
        pg = model_pick(mask, model_ptr);
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
        if (req_ready == 0) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: got no req_ready, required requester %0d", pg);
            req_valid = '0;
            return;
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        ev = '0;
        ev[pg] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(ev));
        chk("busy_at_grant", 64'(busy), 0);
        grant_cyc = cyc;
        plan_d    = d;
        plan_k    = k;
        plan_ik   = ik;
        plan_rg   = rg;
        exp_a0    = req_a0[pg*32 +: 32];
        exp_a1    = req_a1[pg*32 +: 32];
        model_ptr = (pg + 1) % N;
        if (d >= 1 && d <= T) e = '{pg, k, ik, rg, 1'b0, cyc + 2 + d};
        else                  e = '{pg, 32'd0, 32'd0, 3'd0, 1'b1, cyc + 2 + T};
        sb.push_back(e);
        @(posedge clk);
        #1;
        set_ops(pg);
        if (!hold) req_valid = '0;
        for (int w = 0; w < T + 40 && sb.size() != 0; w++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got no res_valid, required id %0d", pg);
            sb.delete();
        end
    endtask

    // Core model: answers each start pulse after plan_d cycles (never when plan_d < 1)
    initial begin
        core_done_m    = 1'b0;
        core_kappa     = $urandom;
        core_inv_kappa = $urandom;
        core_regime    = 3'($urandom);
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && core_start) begin
                chk("start_cycle", 64'(cyc), 64'(grant_cyc + 1));
                chk("core_a0", 64'($unsigned(core_a0)), 64'(exp_a0));
                chk("core_a1", 64'($unsigned(core_a1)), 64'(exp_a1));
                chk("busy_at_start", 64'(busy), 1);
                if (plan_d >= 1) begin
                    repeat (plan_d) @(posedge clk);
                    #1;
                    core_done_m    = 1'b1;
                    core_kappa     = plan_k;
                    core_inv_kappa = plan_ik;
                    core_regime    = plan_rg;
                    @(posedge clk);
                    #1;
                    core_done_m    = 1'b0;
                    core_kappa     = $urandom;
                    core_inv_kappa = $urandom;
                    core_regime    = 3'($urandom);
                end
            end
        end
    end

    // Monitor: every result pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && res_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_res: got res_valid id %0d at cycle %0d, required none", res_id, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("res_cycle", 64'(cyc), 64'(e.at));
                    chk("res_id", 64'(res_id), 64'(e.id));
                    chk("res_kappa", 64'($unsigned(res_kappa)), 64'(e.k));
                    chk("res_inv_kappa", 64'($unsigned(res_inv_kappa)), 64'(e.ik));
                    chk("res_regime", 64'(res_regime), 64'(e.rg));
                    chk("res_timeout", 64'(res_timeout), 64'(e.tmo));
                    chk("busy_at_res", 64'(busy), 1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int d;
        rst_n       = 1'b0;
        req_valid   = '1;
        core_done_s = 1'b0;
        for (int i = 0; i < N; i++) set_ops(i);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ptr = 0;
        @(posedge clk);
        #1;

        // Fairness with every requester continuously asserted
        for (int i = 0; i < 8; i++) begin
            run_txn(4'b1111, 1'b1, int'($urandom_range(1, 6)), $urandom, $urandom, 3'($urandom), g);
            chk("rr_order", 64'(g), 64'(i % 4));
        end

        // Single request from requester 2 with fixed data
        req_a0[2*32 +: 32] = 32'h0004_0000;
        req_a1[2*32 +: 32] = 32'h0001_0000;
        run_txn(4'b0100, 1'b0, 9, 32'h0002_0000, 32'h0000_8000, 3'b001, g);
        chk("single_id", 64'(g), 2);

        // Pointer now 3: wrap and skip over the invalid requesters
        run_txn(4'b1010, 1'b0, 3, $urandom, $urandom, 3'b100, g);
        chk("wrap_first", 64'(g), 3);
        run_txn(4'b1010, 1'b0, 4, $urandom, $urandom, 3'b010, g);
        chk("wrap_second", 64'(g), 1);

        // Timeout with no core reply, then a stray late done
        run_txn(4'b0001, 1'b0, -1, 32'd0, 32'd0, 3'd0, g);
        @(posedge clk);
        #1;
        core_done_s = 1'b1;
        @(posedge clk);
        #1;
        core_done_s = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_after_stray", 64'(busy), 0);
        @(posedge clk);
        #1;

        // Done on the final WAIT cycle wins; one cycle later it is too late
        run_txn(4'b0010, 1'b0, T, 32'hDEAD_BEEF, 32'h8000_0001, 3'b011, g);
        run_txn(4'b0100, 1'b0, T + 1, $urandom, $urandom, 3'b001, g);
        run_txn(4'b1000, 1'b0, 1, $urandom, $urandom, 3'b111, g);

        // Randomized traffic
        repeat (40) begin
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, T + 2));
            run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), d,
                    $urandom, $urandom, 3'($urandom), g);
        end

        // Leave non-zero result data before the reset test
        req_valid = '0;
        @(posedge clk);
        #1;
        run_txn(4'b0001, 1'b0, 2, 32'h1234_5678, 32'h0BAD_F00D, 3'b100, g);

        // Asynchronous reset in the middle of WAIT
        req_valid = 4'b0010;
        for (int w = 0; w < 64 && req_ready == 0; w++) @(negedge clk);
        chk("pre_reset_grant", 64'(req_ready), 64'(4'b0010));
        plan_d    = -1;
        grant_cyc = cyc;
        exp_a0    = req_a0[1*32 +: 32];
        exp_a1    = req_a1[1*32 +: 32];
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("busy_before_reset", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ptr = 0;
        @(posedge clk);
        #1;
        core_done_s = 1'b1;
        @(posedge clk);
        #1;
        core_done_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_reset_stray", 64'(busy), 0);
        @(posedge clk);
        #1;
        run_txn(4'b1111, 1'b0, 3, $urandom, $urandom, 3'b010, g);
        chk("grant_after_reset", 64'(g), 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
